imm_decode_stage: RTL and testbench

Registered, parametrised successor to the combinational immediate generator. It derives the instruction format from the opcode, so no external format select is needed. It sign-extends the immediate to XLEN and computes the PC-relative target. It sits between fetch and decode/execute behind a valid/ready elastic buffer.

---
 rtl/imm_pkg.sv | 49 ++++
 rtl/imm_decode_stage_if.sv | 29 ++
 rtl/imm_extract.sv | 133 +++++++++++++
 rtl/imm_decode_stage.sv | 109 ++++++++++
 tb/tb_imm_decode_stage.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the registered immediate decode stage.
// Opcode map, format codes, RVC quadrant/funct3 values and buffer states.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_R   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [1:0] RVC_Q1   = 2'b01;
  localparam logic [2:0] C3_ADDI  = 3'b000;
  localparam logic [2:0] C3_JAL   = 3'b001;
  localparam logic [2:0] C3_LI    = 3'b010;
  localparam logic [2:0] C3_LUI   = 3'b011;
  localparam logic [2:0] C3_J     = 3'b101;
  localparam logic [2:0] C3_BEQZ  = 3'b110;
  localparam logic [2:0] C3_BNEZ  = 3'b111;

  // Buffer entry: {fmt, immediate, target, illegal}.
  function automatic int payload_width(input int xlen);
    return 3 + 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Valid/ready bus between fetch, the immediate decode stage and decode/execute.
// The stage uses the slave modport; the upstream/downstream side uses master.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
) ();
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  fmt_e            out_fmt;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] target;
  logic            illegal;

  modport master (
    output in_valid, instruction, pc, out_ready,
    input  in_ready, out_valid, out_fmt, immediate, target, illegal
  );

  modport slave (
    input  in_valid, instruction, pc, out_ready,
    output in_ready, out_valid, out_fmt, immediate, target, illegal
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational format/immediate extraction from a raw instruction word.
// Compressed decode is present only when IMM_RVC_EN is defined.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction_i,
  output fmt_e            fmt_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o,
  output logic            pcrel_o,
  output logic            compressed_o
);

  logic [6:0]      opc_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] imm_j_s;

  assign opc_s   = instruction_i[6:0];
  assign imm_i_s = XLEN'($signed(instruction_i[31:20]));
  assign imm_s_s = XLEN'($signed({instruction_i[31:25], instruction_i[11:7]}));
  assign imm_b_s = XLEN'($signed({instruction_i[31], instruction_i[7],
                                  instruction_i[30:25], instruction_i[11:8], 1'b0}));
  assign imm_u_s = XLEN'($signed({instruction_i[31:12], 12'b0}));
  assign imm_j_s = XLEN'($signed({instruction_i[31], instruction_i[19:12],
                                  instruction_i[20], instruction_i[30:21], 1'b0}));

`ifdef IMM_RVC_EN
  logic [XLEN-1:0] imm_ci_s;
  logic [XLEN-1:0] imm_clui_s;
  logic [XLEN-1:0] imm_cj_s;
  logic [XLEN-1:0] imm_cb_s;

  assign imm_ci_s   = XLEN'($signed({instruction_i[12], instruction_i[6:2]}));
  assign imm_clui_s = XLEN'($signed({instruction_i[12], instruction_i[6:2], 12'b0}));
  assign imm_cj_s   = XLEN'($signed({instruction_i[12], instruction_i[8], instruction_i[10:9],
                                     instruction_i[6], instruction_i[7], instruction_i[2],
                                     instruction_i[11], instruction_i[5:3], 1'b0}));
  assign imm_cb_s   = XLEN'($signed({instruction_i[12], instruction_i[6:5], instruction_i[2],
                                     instruction_i[11:10], instruction_i[4:3], 1'b0}));
`endif

  // Format decode; anything unrecognised falls through to ILL with a zero immediate.
  always_comb begin
    fmt_o        = FMT_ILL;
    imm_o        = '0;
    illegal_o    = 1'b1;
    pcrel_o      = 1'b0;
    compressed_o = 1'b0;
    if (instruction_i[1:0] == 2'b11) begin
      case (opc_s)
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
          fmt_o = FMT_I; imm_o = imm_i_s; illegal_o = 1'b0;
        end
        OPC_STORE: begin
          fmt_o = FMT_S; imm_o = imm_s_s; illegal_o = 1'b0;
        end
        OPC_BRANCH: begin
          fmt_o = FMT_B; imm_o = imm_b_s; illegal_o = 1'b0; pcrel_o = 1'b1;
        end
        OPC_LUI: begin
          fmt_o = FMT_U; imm_o = imm_u_s; illegal_o = 1'b0;
        end
        OPC_AUIPC: begin
          fmt_o = FMT_U; imm_o = imm_u_s; illegal_o = 1'b0; pcrel_o = 1'b1;
        end
        OPC_JAL: begin
          fmt_o = FMT_J; imm_o = imm_j_s; illegal_o = 1'b0; pcrel_o = 1'b1;
        end
        OPC_OP: begin
          fmt_o = FMT_R; illegal_o = 1'b0;
        end
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            fmt_o = FMT_I; imm_o = imm_i_s; illegal_o = 1'b0;
          end else begin
            fmt_o = FMT_ILL;
          end
        end
        OPC_OP_32: begin
          if (XLEN == 64) begin
            fmt_o = FMT_R; illegal_o = 1'b0;
          end else begin
            fmt_o = FMT_ILL;
          end
        end
        default: fmt_o = FMT_ILL;
      endcase
    end else begin
`ifdef IMM_RVC_EN
      compressed_o = 1'b1;
      if (instruction_i[1:0] == RVC_Q1) begin
        case (instruction_i[15:13])
          C3_ADDI, C3_LI: begin
            fmt_o = FMT_I; imm_o = imm_ci_s; illegal_o = 1'b0;
          end
          C3_JAL: begin
            // In RV64 this slot is C.ADDIW, which is not decoded here.
            if (XLEN == 32) begin
              fmt_o = FMT_J; imm_o = imm_cj_s; illegal_o = 1'b0; pcrel_o = 1'b1;
            end else begin
              fmt_o = FMT_ILL;
            end
          end
          C3_LUI: begin
            if ((instruction_i[11:7] != 5'd2) && (imm_ci_s != '0)) begin
              fmt_o = FMT_U; imm_o = imm_clui_s; illegal_o = 1'b0;
            end else begin
              fmt_o = FMT_ILL;
            end
          end
          C3_J: begin
            fmt_o = FMT_J; imm_o = imm_cj_s; illegal_o = 1'b0; pcrel_o = 1'b1;
          end
          C3_BEQZ, C3_BNEZ: begin
            fmt_o = FMT_B; imm_o = imm_cb_s; illegal_o = 1'b0; pcrel_o = 1'b1;
          end
          default: fmt_o = FMT_ILL;
        endcase
      end else begin
        fmt_o = FMT_ILL;
      end
`else
      fmt_o = FMT_ILL;
`endif
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage behind a main+skid elastic buffer.
// Optional compressed decode is enabled by defining IMM_RVC_EN.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               reset,
  imm_decode_stage_if.slave bus
);

  localparam int              PW        = payload_width(XLEN);
  localparam logic [XLEN-1:0] STEP_FULL = XLEN'(32'd4);
  localparam logic [XLEN-1:0] STEP_HALF = XLEN'(32'd2);

  fmt_e            fmt_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] target_s;
  logic            illegal_s;
  logic            pcrel_s;
  logic            compressed_s;
  logic [PW-1:0]   in_payload_s;
  logic            accept_s;
  logic            consume_s;

  buf_state_e      state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic            in_ready_q;
  logic            out_valid_q;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instruction_i (bus.instruction),
    .fmt_o         (fmt_s),
    .imm_o         (imm_s),
    .illegal_o     (illegal_s),
    .pcrel_o       (pcrel_s),
    .compressed_o  (compressed_s)
  );

  assign target_s     = bus.pc + (pcrel_s ? imm_s : (compressed_s ? STEP_HALF : STEP_FULL));
  assign in_payload_s = {fmt_s, imm_s, target_s, illegal_s};
  assign accept_s     = bus.in_valid & in_ready_q;
  assign consume_s    = out_valid_q & bus.out_ready;

  // Buffer next state: main holds the oldest entry, skid only fills while main stalls.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept_s) begin
          state_d = BUF_ONE;
          main_d  = in_payload_s;
        end else begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (accept_s && consume_s) begin
          main_d = in_payload_s;
        end else if (accept_s) begin
          state_d = BUF_FULL;
          skid_d  = in_payload_s;
        end else if (consume_s) begin
          state_d = BUF_EMPTY;
        end else begin
          state_d = BUF_ONE;
        end
      end
      BUF_FULL: begin
        if (consume_s) begin
          state_d = BUF_ONE;
          main_d  = skid_q;
        end else begin
          state_d = BUF_FULL;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // State and payload registers; handshake outputs are registered copies of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BUF_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != BUF_FULL);
      out_valid_q <= (state_d != BUF_EMPTY);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_fmt   = fmt_e'(main_q[PW-1 -: 3]);
  assign bus.immediate = main_q[PW-4 -: XLEN];
  assign bus.target    = main_q[XLEN:1];
  assign bus.illegal   = main_q[0];

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances in lockstep,
// checked against a queue-based reference model plus directed literals.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] pc;
  int          total = 0;
  int          bad = 0;
  int          cons_cnt = 0;
  bit          acc_f = 1'b0;
  bit          cons_f = 1'b0;

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f32;
    logic [31:0] i32;
    logic [31:0] t32;
    logic        l32;
    logic [2:0]  f64;
    logic [63:0] i64;
    logic [63:0] t64;
    logic        l64;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  imm_decode_stage_if #(.XLEN(32)) bus32 ();
  imm_decode_stage_if #(.XLEN(64)) bus64 ();

  assign bus32.in_valid    = in_valid;
  assign bus32.instruction = instr;
  assign bus32.pc          = pc[31:0];
  assign bus32.out_ready   = out_ready;
  assign bus64.in_valid    = in_valid;
  assign bus64.instruction = instr;
  assign bus64.pc          = pc;
  assign bus64.out_ready   = out_ready;

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .reset(rst), .bus(bus32));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .reset(rst), .bus(bus64));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Value of an n-bit two's-complement field.
  function automatic longint sx(input longint v, input int n);
    return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
  endfunction

  // Reference decode: format code, immediate value, pc-relative flag, 16-bit flag.
  function automatic void ref_decode(input bit x64, input logic [31:0] w, output logic [2:0] f,
                                     output longint imm, output bit rel, output bit half);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[15:13];
    f = 3'd7; imm = 0; rel = 1'b0; half = 1'b0;
    if (w[1:0] == 2'b11) begin
      if (op inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h0F} || (x64 && op == 7'h1B)) begin
        f = 3'd0; imm = sx(w[31:20], 12);
      end else if (op == 7'h23) begin
        f = 3'd1; imm = sx({w[31:25], w[11:7]}, 12);
      end else if (op == 7'h63) begin
        f = 3'd2; imm = sx({w[31], w[7], w[30:25], w[11:8], 1'b0}, 13); rel = 1'b1;
      end else if (op == 7'h37 || op == 7'h17) begin
        f = 3'd3; imm = sx(w[31:12], 20) * 4096; rel = (op == 7'h17);
      end else if (op == 7'h6F) begin
        f = 3'd4; imm = sx({w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); rel = 1'b1;
      end else if (op == 7'h33 || (x64 && op == 7'h3B)) begin
        f = 3'd5;
      end
    end
`ifdef IMM_RVC_EN
    else begin
      half = 1'b1;
      if (w[1:0] == 2'b01) begin
        if (f3 == 3'd0 || f3 == 3'd2) begin
          f = 3'd0; imm = sx({w[12], w[6:2]}, 6);
        end else if ((f3 == 3'd1 && !x64) || f3 == 3'd5) begin
          f = 3'd4; rel = 1'b1;
          imm = sx({w[12], w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0}, 12);
        end else if (f3 == 3'd3 && w[11:7] != 5'd2 && {w[12], w[6:2]} != 6'd0) begin
          f = 3'd3; imm = sx({w[12], w[6:2]}, 6) * 4096;
        end else if (f3 >= 3'd6) begin
          f = 3'd2; rel = 1'b1;
          imm = sx({w[12], w[6:5], w[2], w[11:10], w[4:3], 1'b0}, 9);
        end
      end
    end
`endif
  endfunction

  function automatic exp_t model(input logic [31:0] w, input logic [63:0] p);
    exp_t       e;
    logic [2:0] f;
    longint     imm;
    bit         rel, half;
    logic [63:0] t;
    ref_decode(1'b0, w, f, imm, rel, half);
    t = {32'd0, p[31:0]} + (rel ? imm : (half ? 64'd2 : 64'd4));
    e.f32 = f; e.i32 = imm[31:0]; e.t32 = t[31:0]; e.l32 = (f == 3'd7);
    ref_decode(1'b1, w, f, imm, rel, half);
    t = p + (rel ? imm : (half ? 64'd2 : 64'd4));
    e.f64 = f; e.i64 = imm; e.t64 = t; e.l64 = (f == 3'd7);
    return e;
  endfunction

  // Every cycle outside reset: occupancy and head-of-queue outputs must match the model.
  always @(negedge clk) begin
    acc_f  = 1'b0;
    cons_f = 1'b0;
    if (!rst) begin
      acc_f  = in_valid && bus32.in_ready;
      cons_f = bus32.out_valid && out_ready;
      check("out_valid32", bus32.out_valid, exp_q.size() > 0);
      check("out_valid64", bus64.out_valid, exp_q.size() > 0);
      check("in_ready32", bus32.in_ready, exp_q.size() < 2);
      check("in_ready64", bus64.in_ready, exp_q.size() < 2);
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        check("fmt32", bus32.out_fmt, cur.f32);
        check("imm32", bus32.immediate, cur.i32);
        check("tgt32", bus32.target, cur.t32);
        check("ill32", bus32.illegal, cur.l32);
        check("fmt64", bus64.out_fmt, cur.f64);
        check("imm64", bus64.immediate, cur.i64);
        check("tgt64", bus64.target, cur.t64);
        check("ill64", bus64.illegal, cur.l64);
      end
    end
  end

  // Scoreboard update on the transfers seen at the preceding falling edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (cons_f && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        cons_cnt++;
      end
      if (acc_f) exp_q.push_back(model(instr, pc));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input logic [31:0] w, input logic [63:0] p);
    int n;
    n = 0;
    in_valid = 1'b1; instr = w; pc = p;
    forever begin
      @(negedge clk);
      if (bus32.in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL send_timeout: word %h not accepted within 50 cycles", w);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ov32"}, bus32.out_valid, 1'b0);
    check({tag, "_ir32"}, bus32.in_ready, 1'b1);
    check({tag, "_fmt32"}, bus32.out_fmt, 3'd0);
    check({tag, "_imm32"}, bus32.immediate, 32'd0);
    check({tag, "_tgt32"}, bus32.target, 32'd0);
    check({tag, "_ill32"}, bus32.illegal, 1'b0);
    check({tag, "_ov64"}, bus64.out_valid, 1'b0);
    check({tag, "_ir64"}, bus64.in_ready, 1'b1);
  endtask

  localparam int NV = 15;
  logic [31:0] vw [NV] = '{32'h00A00093, 32'hFF1FF0EF, 32'h0000007F, 32'h800000B7,
                           32'h123450B7, 32'hFE112C23, 32'hFE000EE3, 32'h80000097,
                           32'h002081B3, 32'h0000101B, 32'h0080006F, 32'h000050FD,
                           32'hFFF00013, 32'h00000001, 32'h7FFFF0B7};
  logic [63:0] vp [NV] = '{64'h0, 64'h100, 64'h200, 64'h300,
                           64'h304, 64'h308, 64'h40, 64'h80000000,
                           64'h20, 64'h24, 64'hFFFFFFFC, 64'h10,
                           64'h1000, 64'h50, 64'h54};

  initial begin
    exp_t m;
    int   base;
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 64'd0; out_ready = 1'b1;

    // Hand-computed values pinning the reference model.
    m = model(32'h00A00093, 64'h0);
    check("pin_addi_fmt", m.f32, 3'd0);
    check("pin_addi_imm", m.i32, 32'h0000000A);
    check("pin_addi_tgt", m.t32, 32'h00000004);
    m = model(32'hFFDFF0EF, 64'h100);
    check("pin_jal_m4_imm", m.i32, 32'hFFFFFFFC);
    check("pin_jal_m4_tgt", m.t32, 32'h000000FC);
    // 0xFF1FF0EF carries imm[10:1]=0x3F8, i.e. an offset of -16.
    m = model(32'hFF1FF0EF, 64'h100);
    check("pin_jal_m16_imm", m.i32, 32'hFFFFFFF0);
    m = model(32'h800000B7, 64'h0);
    check("pin_lui_neg64", m.i64, 64'hFFFFFFFF80000000);
    m = model(32'h123450B7, 64'h0);
    check("pin_lui_pos64", m.i64, 64'h0000000012345000);
    m = model(32'h80000097, 64'h80000000);
    check("pin_auipc_wrap32", m.t32, 32'h0);
    check("pin_auipc_wrap64", m.t64, 64'h0);
    m = model(32'h0080006F, 64'hFFFFFFFC);
    check("pin_jal_wrap32", m.t32, 32'h4);
    check("pin_jal_nowrap64", m.t64, 64'h100000004);
    m = model(32'h0000101B, 64'h24);
    check("pin_addiw_32", m.f32, 3'd7);
    check("pin_addiw_64", m.f64, 3'd0);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    send(32'h00A00093, 64'h0);
    check("addi_ov", bus32.out_valid, 1'b1);
    check("addi_fmt", bus32.out_fmt, 3'd0);
    check("addi_imm", bus32.immediate, 32'h0000000A);
    check("addi_tgt", bus32.target, 32'h00000004);
    send(32'hFFDFF0EF, 64'h100);
    check("jal_fmt", bus32.out_fmt, 3'd4);
    check("jal_imm", bus32.immediate, 32'hFFFFFFFC);
    check("jal_tgt", bus32.target, 32'h000000FC);
    send(32'h0000007F, 64'h200);
    check("ill_flag", bus32.illegal, 1'b1);
    check("ill_fmt", bus32.out_fmt, 3'd7);
    check("ill_imm", bus32.immediate, 32'h0);
    check("ill_tgt", bus32.target, 32'h204);
    send(32'h800000B7, 64'h0);
    check("lui_neg64", bus64.immediate, 64'hFFFFFFFF80000000);
    check("lui_neg32", bus32.immediate, 32'h80000000);
    send(32'h123450B7, 64'h0);
    check("lui_pos64", bus64.immediate, 64'h0000000012345000);
    send(32'h000050FD, 64'h10);
`ifdef IMM_RVC_EN
    check("cli_fmt", bus32.out_fmt, 3'd0);
    check("cli_imm", bus32.immediate, 32'hFFFFFFFF);
    check("cli_tgt", bus32.target, 32'h00000012);
`else
    check("cli_ill", bus32.illegal, 1'b1);
    check("cli_fmt", bus32.out_fmt, 3'd7);
`endif
    drain(20);

    // Backpressure: two words fill main and skid, the third waits for space.
    out_ready = 1'b0;
    base = cons_cnt;
    send(32'h00100093, 64'h400);
    check("bp_ready_one", bus32.in_ready, 1'b1);
    send(32'h00200093, 64'h404);
    check("bp_ready_full", bus32.in_ready, 1'b0);
    check("bp_valid_full", bus32.out_valid, 1'b1);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(32'h00300093, 64'h408);
    drain(20);
    check("bp_count", cons_cnt - base, 3);

    // Mixed stream under a stalling consumer.
    fork
      begin
        for (int i = 0; i < NV; i++) send(vw[i], vp[i]);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk); #1;
          out_ready = (k % 3 != 2);
        end
      end
    join
    drain(40);

    // Reset while full discards both entries at once.
    out_ready = 1'b0;
    send(32'h00500093, 64'h500);
    send(32'h00600093, 64'h504);
    check("pre_reset_full", bus32.in_ready, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    base = cons_cnt;
    out_ready = 1'b1;
    send(32'h00700093, 64'h600);
    repeat (4) @(posedge clk);
    #1;
    check("after_reset_count", cons_cnt - base, 1);
    check("after_reset_idle", bus32.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
